clk_frame_gen: RTL

Parametrised bit-clock and frame-sync generator for the codec/ADC serial audio ports. It divides `CLK_IN` into `BCLK` and a frame sync `FSYNC` for 2-channel I2S or N-slot TDM frames at 48/96/192/384 kHz. It also provides one-cycle edge strobes, slot and bit indices, and a frame-start strobe. Rate changes are applied glitch-free, only at frame boundaries. Serialisers and deserialisers in the `CLK_IN` domain use its strobes instead of sampling `BCLK`.

---
 rtl/clk_frame_gen.sv | 127 ++++++++++++
 1 files changed

// File: rtl/clk_frame_gen.sv
// Bit-clock / frame-sync generator: divides CLK_IN into BCLK and FSYNC for I2S or TDM
// frames, with CLK_IN-domain edge strobes and frame-aligned, glitch-free rate switching.
module clk_frame_gen #(
    parameter int unsigned CLK_FREQ    = 122880000,
    parameter int unsigned CHANNELS    = 2,
    parameter int unsigned SLOT_BITS   = 32,
    parameter int unsigned FSYNC_PULSE = 0
) (
    input  logic                          CLK_IN,
    input  logic                          reset,
    input  logic [1:0]                    Speed,
    output logic                          BCLK,
    output logic                          Brise,
    output logic                          Bfall,
    output logic                          FSYNC,
    output logic                          Fstart,
    output logic [$clog2(CHANNELS)-1:0]   SLOT,
    output logic [4:0]                    BIT,
    output logic [1:0]                    Speed_active
);
    localparam int SW = $clog2(CHANNELS);

    function automatic longint bdiv_full(input int s);
        return longint'(CLK_FREQ) /
               (longint'(48000) * (longint'(1) << s) * longint'(CHANNELS) * longint'(SLOT_BITS));
    endfunction

    localparam longint BD_MIN = bdiv_full(3);
    localparam longint BD_MAX = bdiv_full(0);

    localparam logic [15:0] BD0 = 16'(bdiv_full(0));
    localparam logic [15:0] BD1 = 16'(bdiv_full(1));
    localparam logic [15:0] BD2 = 16'(bdiv_full(2));
    localparam logic [15:0] BD3 = 16'(bdiv_full(3));

    localparam logic [SW-1:0] SLOT_LAST = SW'(CHANNELS - 1);
    localparam logic [SW-1:0] SLOT_HALF = SW'(CHANNELS / 2);
    localparam logic [4:0]    BIT_TOP   = 5'(SLOT_BITS - 1);

    // Reject configurations the divider cannot produce cleanly.
    if (BD_MIN < 2 || BD_MAX > 65535) begin : g_bad_div
        $error("clk_frame_gen: BDIV out of range 2..65535 for some Speed");
    end
    if (CHANNELS < 2 || (CHANNELS % 2) != 0) begin : g_bad_ch
        $error("clk_frame_gen: CHANNELS must be even and >= 2");
    end
    if (SLOT_BITS < 8 || SLOT_BITS > 32) begin : g_bad_sb
        $error("clk_frame_gen: SLOT_BITS must be 8..32");
    end

    function automatic logic [15:0] bdiv_sel(input logic [1:0] s);
        case (s)
            2'b00:   return BD0;
            2'b01:   return BD1;
            2'b10:   return BD2;
            default: return BD3;
        endcase
    endfunction

    logic [15:0]   bcnt, bcnt_n, div_cur, div_next;
    logic          wrap, frame_end;
    logic          bclk_n, brise_n, fsync_n;
    logic [SW-1:0] slot_n;
    logic [4:0]    bit_n;
    logic [1:0]    spd_n;

    always_comb begin
        div_cur   = bdiv_sel(Speed_active);
        wrap      = (bcnt == div_cur - 16'd1);
        frame_end = wrap && (SLOT == SLOT_LAST) && (BIT == 5'd0);
        spd_n     = Speed_active;
        div_next  = div_cur;
        bcnt_n    = bcnt + 16'd1;
        slot_n    = SLOT;
        bit_n     = BIT;

        // The new rate takes over exactly at the wrap that starts the next frame,
        // so the period ending here is still a full old-rate period.
        if (frame_end) begin
            spd_n    = Speed;
            div_next = bdiv_sel(Speed);
        end

        if (wrap) begin
            bcnt_n = 16'd0;
            if (BIT == 5'd0) begin
                bit_n  = BIT_TOP;
                slot_n = (SLOT == SLOT_LAST) ? '0 : SLOT + SW'(1);
            end else begin
                bit_n = BIT - 5'd1;
            end
        end

        bclk_n  = (bcnt_n >= (div_next >> 1));
        brise_n = (bcnt_n == (div_next >> 1));

        if (FSYNC_PULSE != 0)
            fsync_n = (slot_n == '0) && (bit_n == BIT_TOP);
        else
            fsync_n = (slot_n >= SLOT_HALF);
    end

    always_ff @(posedge CLK_IN or posedge reset) begin
        if (reset) begin
            bcnt         <= BD0 - 16'd1;
            BCLK         <= 1'b0;
            Brise        <= 1'b0;
            Bfall        <= 1'b0;
            Fstart       <= 1'b0;
            SLOT         <= SLOT_LAST;
            BIT          <= 5'd0;
            FSYNC        <= (FSYNC_PULSE == 0);
            Speed_active <= 2'b00;
        end else begin
            bcnt         <= bcnt_n;
            BCLK         <= bclk_n;
            Brise        <= brise_n;
            Bfall        <= wrap;
            Fstart       <= frame_end;
            SLOT         <= slot_n;
            BIT          <= bit_n;
            FSYNC        <= fsync_n;
            Speed_active <= spd_n;
        end
    end

endmodule
